result_trace_buffer: RTL

Synthesizable capture buffer for the CPU's ALU result stream, generalising the fixed 19-bit result monitor into a parametrised on-chip trace.
- Arm: a single-cycle pulse on `arm` starts a capture run.
- Trigger: capture optionally waits for a trigger value.
- Storage: up to DEPTH valid samples in stop-on-full or wrap (ring) mode.
- Readout: oldest-first over a valid/ready port.
- Placement: next to the CPU core, fed from its `alu_result` path.

---
 rtl/result_trace_buffer_pkg.sv | 21 ++
 rtl/result_trace_buffer_ram.sv | 37 +++
 rtl/result_trace_buffer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/result_trace_buffer_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg : shared types and constants for the ALU result trace buffer.
//   trace_state_e : capture FSM states (IDLE, ARMED, CAPTURE, DONE)
//   MODE_STOP/WRAP: storage mode selected at arm time
//   TS_W          : timestamp width used when TRACE_TIMESTAMP_EN is defined
// ---------------------------------------------------------------------------
package trace_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } trace_state_e;

   localparam logic MODE_STOP = 1'b0;
   localparam logic MODE_WRAP = 1'b1;

   localparam int TS_W = 16;

endpackage

// File: rtl/result_trace_buffer_ram.sv
// ---------------------------------------------------------------------------
// trace_ram : DEPTH x WIDTH trace storage.
//   One synchronous write port (we/waddr/wdata, rising clk) and one
//   asynchronous read port (raddr -> rdata). Contents are not reset.
// Ports:
//   clk   in   system clock
//   we    in   write enable
//   waddr in   write address
//   wdata in   write data
//   raddr in   read address
//   rdata out  read data (combinational)
// ---------------------------------------------------------------------------
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 19,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Storage write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/result_trace_buffer.sv
// ---------------------------------------------------------------------------
// result_trace_buffer : on-chip capture buffer for the CPU alu_result stream.
//   A pulse on arm starts a run (optionally waiting for trig_value), samples
//   are stored in stop-on-full or wrap mode, and after stop (or full) the
//   entries are read out oldest-first over a valid/ready port.
// Optional feature macro: TRACE_TIMESTAMP_EN (adds a 16-bit saturating cycle
//   timestamp per entry and the rd_ts output).
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   arm, stop            single-cycle run control pulses
//   mode, trig_en,
//   trig_value           run configuration, sampled at arm
//   sample_valid,
//   sample_data          sample stream
//   rd_ready             consumer accept
//   rd_valid, rd_data    oldest stored entry (DONE only)
//   count                entries held, 0..DEPTH
//   state                FSM state (trace_state_e encoding)
//   overflow             sticky wrap-overwrite flag for the current run
//   rd_ts                timestamp of rd_data entry (TRACE_TIMESTAMP_EN only)
// ---------------------------------------------------------------------------
module result_trace_buffer
   import trace_pkg::*;
#(
   parameter int DATA_W = 19,
   parameter int DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       arm,
   input  logic                       stop,
   input  logic                       mode,
   input  logic                       trig_en,
   input  logic [DATA_W-1:0]          trig_value,
   input  logic                       sample_valid,
   input  logic [DATA_W-1:0]          sample_data,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [DATA_W-1:0]          rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic [1:0]                 state,
   output logic                       overflow
`ifdef TRACE_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]            rd_ts
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
   localparam int MEM_W = DATA_W + TS_W;
`else
   localparam int MEM_W = DATA_W;
`endif

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_LAST = (PTR_W+1)'(DEPTH - 1);

   trace_state_e        state_r,      state_nxt_s;
   logic                mode_r,       mode_nxt_s;
   logic [DATA_W-1:0]   trig_value_r, trig_value_nxt_s;
   logic [PTR_W-1:0]    wr_ptr_r,     wr_ptr_nxt_s;
   logic [PTR_W-1:0]    rd_ptr_r,     rd_ptr_nxt_s;
   logic [PTR_W:0]      count_r,      count_nxt_s;
   logic                overflow_r,   overflow_nxt_s;
   logic                we_s;
   logic                trig_hit_s;
   logic                full_s;
   logic [MEM_W-1:0]    wdata_s;
   logic [MEM_W-1:0]    rdata_s;

   assign trig_hit_s = sample_valid && (sample_data == trig_value_r);
   assign full_s     = (count_r == CNT_FULL);

   // Next-state, pointer and counter logic for the capture FSM.
   always_comb begin
      state_nxt_s      = state_r;
      mode_nxt_s       = mode_r;
      trig_value_nxt_s = trig_value_r;
      wr_ptr_nxt_s     = wr_ptr_r;
      rd_ptr_nxt_s     = rd_ptr_r;
      count_nxt_s      = count_r;
      overflow_nxt_s   = overflow_r;
      we_s             = 1'b0;

      case (state_r)
         IDLE: begin
            if (arm) begin
               mode_nxt_s       = mode;
               trig_value_nxt_s = trig_value;
               wr_ptr_nxt_s     = '0;
               rd_ptr_nxt_s     = '0;
               count_nxt_s      = CNT_ZERO;
               overflow_nxt_s   = 1'b0;
               state_nxt_s      = trig_en ? ARMED : CAPTURE;
            end else begin
               state_nxt_s = IDLE;
            end
         end

         ARMED: begin
            // The matching sample is the first entry of the run.
            if (trig_hit_s) begin
               we_s         = 1'b1;
               wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
               count_nxt_s  = count_r + CNT_ONE;
               state_nxt_s  = CAPTURE;
            end else begin
               state_nxt_s = ARMED;
            end
            // A stop with a same-cycle trigger keeps that entry for readout.
            if (stop) begin
               state_nxt_s = trig_hit_s ? DONE : IDLE;
            end else begin
               state_nxt_s = state_nxt_s;
            end
         end

         CAPTURE: begin
            if (sample_valid) begin
               if (!full_s) begin
                  we_s         = 1'b1;
                  wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                  count_nxt_s  = count_r + CNT_ONE;
                  if ((mode_r == MODE_STOP) && (count_r == CNT_LAST)) begin
                     state_nxt_s = DONE;
                  end else begin
                     state_nxt_s = CAPTURE;
                  end
               end else if (mode_r == MODE_WRAP) begin
                  // Ring overwrite: oldest entry is dropped, read pointer follows.
                  we_s           = 1'b1;
                  wr_ptr_nxt_s   = wr_ptr_r + PTR_ONE;
                  rd_ptr_nxt_s   = rd_ptr_r + PTR_ONE;
                  overflow_nxt_s = 1'b1;
               end else begin
                  we_s = 1'b0;
               end
            end else begin
               we_s = 1'b0;
            end
            if (stop) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = state_nxt_s;
            end
         end

         DONE: begin
            if (count_r == CNT_ZERO) begin
               state_nxt_s = IDLE;
            end else if (rd_ready) begin
               rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
               count_nxt_s  = count_r - CNT_ONE;
               state_nxt_s  = (count_r == CNT_ONE) ? IDLE : DONE;
            end else begin
               state_nxt_s = DONE;
            end
         end

         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM and run bookkeeping registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         mode_r       <= MODE_STOP;
         trig_value_r <= '0;
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         count_r      <= CNT_ZERO;
         overflow_r   <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         mode_r       <= mode_nxt_s;
         trig_value_r <= trig_value_nxt_s;
         wr_ptr_r     <= wr_ptr_nxt_s;
         rd_ptr_r     <= rd_ptr_nxt_s;
         count_r      <= count_nxt_s;
         overflow_r   <= overflow_nxt_s;
      end
   end

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_r;

   // Saturating run-relative cycle counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts_r <= '0;
      end else if ((state_r == IDLE) && arm) begin
         ts_r <= '0;
      end else if (((state_r == ARMED) || (state_r == CAPTURE)) && (ts_r != 16'hFFFF)) begin
         ts_r <= ts_r + 16'd1;
      end
   end

   assign wdata_s = {ts_r, sample_data};
   assign rd_ts   = rd_valid ? rdata_s[MEM_W-1:DATA_W] : '0;
`else
   assign wdata_s = sample_data;
`endif

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (MEM_W),
      .AW    (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (we_s),
      .waddr (wr_ptr_r),
      .wdata (wdata_s),
      .raddr (rd_ptr_r),
      .rdata (rdata_s)
   );

   assign rd_valid = (state_r == DONE) && (count_r != CNT_ZERO);
   assign rd_data  = rd_valid ? rdata_s[DATA_W-1:0] : '0;
   assign count    = count_r;
   assign state    = state_r;
   assign overflow = overflow_r;

endmodule
